rd53_sync_fe_tot_ctrl: RTL and testbench

// - Per-pixel digital back-end of the synchronous analog front-end, directly downstream of its discriminator.
// - Drives auto-zero (PHI_AZ) and latch STROBE timing and samples the latched discriminator output every cycle.
// - Measures time-over-threshold (ToT) with a saturating counter and tags each hit with the leading-edge BCID.
// - Emits one hit record per pulse over a valid/ready handshake to the pixel-region buffer.

---
 rtl/rd53_sync_fe_pkg.sv | 25 ++
 rtl/rd53_sync_fe_tot_ctrl_if.sv | 13 +
 rtl/rd53_az_sched.sv | 54 +++++
 rtl/rd53_sync_fe_tot_ctrl.sv | 154 +++++++++++++++
 tb/tb_rd53_sync_fe_tot_ctrl.sv | 362 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rd53_sync_fe_pkg.sv
// Shared types for the synchronous front-end ToT controller: FSM states,
// hit record layout and default field widths.
package rd53_sync_fe_pkg;

   localparam int TOT_W_DEF  = 4;
   localparam int BCID_W_DEF = 8;

   typedef enum logic [1:0] {
      ACQ   = 2'd0,
      TOT   = 2'd1,
      AZ    = 2'd2,
      GUARD = 2'd3
   } sync_fe_state_t;

   typedef struct packed {
      logic [TOT_W_DEF-1:0]  tot;
      logic [BCID_W_DEF-1:0] ts;
   } hit_rec_t;

   // States in which the discriminator is blind and auto-zero requests are absorbed.
   function automatic logic az_busy(sync_fe_state_t s);
      return (s == AZ) || (s == GUARD);
   endfunction

endpackage

// File: rtl/rd53_sync_fe_tot_ctrl_if.sv
// Hit record handshake between the pixel back-end and the pixel-region buffer.
interface rd53_sync_fe_tot_ctrl_if #(
   parameter int TOT_W  = 4,
   parameter int BCID_W = 8
);
   logic              valid;
   logic              ready;
   logic [TOT_W-1:0]  tot;
   logic [BCID_W-1:0] ts;

   modport master (output valid, output tot, output ts, input ready);
   modport slave  (input valid, input tot, input ts, output ready);
endinterface

// File: rtl/rd53_az_sched.sv
// Auto-zero scheduler: free-running period counter plus the pending flag that
// the FSM consumes when it next has a quiet ACQ cycle.
module rd53_az_sched #(
   parameter int AZ_PERIOD = 1000
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic az_req_i,
   input  logic busy_i,
   input  logic az_enter_i,
   output logic az_pending_o
);
   localparam int PER_W = (AZ_PERIOD > 1) ? $clog2(AZ_PERIOD) : 1;

   logic [PER_W-1:0] per_q, per_d;
   logic             tick;
   logic             pend_q, pend_d;

   generate
      if (AZ_PERIOD > 0) begin : g_per
         always_comb begin
            tick  = (per_q == PER_W'(AZ_PERIOD - 1));
            per_d = tick ? '0 : per_q + 1'b1;
         end
      end else begin : g_no_per
         always_comb begin
            tick  = 1'b0;
            per_d = '0;
         end
      end
   endgenerate

   // Entry to AZ wins over a same-cycle request; requests while busy are dropped.
   always_comb begin
      pend_d = pend_q;
      if (az_enter_i)
         pend_d = 1'b0;
      else if (!busy_i && (az_req_i || tick))
         pend_d = 1'b1;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         per_q  <= '0;
         pend_q <= 1'b0;
      end else begin
         per_q  <= per_d;
         pend_q <= pend_d;
      end
   end

   assign az_pending_o = pend_q;

endmodule

// File: rtl/rd53_sync_fe_tot_ctrl.sv
// Per-pixel back-end for the synchronous AFE: auto-zero/strobe sequencing,
// saturating ToT measurement with leading-edge BCID and a one-deep hit register.
module rd53_sync_fe_tot_ctrl
   import rd53_sync_fe_pkg::*;
#(
   parameter int TOT_W     = TOT_W_DEF,
   parameter int BCID_W    = BCID_W_DEF,
   parameter int AZ_PERIOD = 1000,
   parameter int AZ_WIDTH  = 4,
   parameter int AZ_GUARD  = 2
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    en_i,
   input  logic                    disc_i,
   input  logic [BCID_W-1:0]       bcid_i,
   input  logic                    az_req_i,
   output logic                    phi_az_o,
   output logic                    strobe_o,
   output logic                    ovf_o,
   rd53_sync_fe_tot_ctrl_if.master hit_o
);
   localparam int CNT_MAX = (AZ_WIDTH > AZ_GUARD) ? AZ_WIDTH : AZ_GUARD;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   sync_fe_state_t    state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              prev_q, prev_d;
   logic [TOT_W-1:0]  tot_q, tot_d;
   logic [BCID_W-1:0] ts_q, ts_d;
   logic              phi_q, strobe_q;
   logic              vld_q, ovf_q;
   logic [TOT_W-1:0]  otot_q;
   logic [BCID_W-1:0] ots_q;
   logic              az_pending, az_enter, emit, pop;

   rd53_az_sched #(.AZ_PERIOD(AZ_PERIOD)) u_az_sched (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .az_req_i     (az_req_i),
      .busy_i       (az_busy(state_q)),
      .az_enter_i   (az_enter),
      .az_pending_o (az_pending)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      prev_d   = disc_i;
      tot_d    = tot_q;
      ts_d     = ts_q;
      emit     = 1'b0;
      az_enter = 1'b0;
      unique case (state_q)
         ACQ: begin
            if (en_i && disc_i && !prev_q) begin
               state_d = TOT;
               ts_d    = bcid_i;
               tot_d   = TOT_W'(1);
            end else if (az_pending) begin
               state_d  = AZ;
               cnt_d    = CNT_W'(AZ_WIDTH);
               az_enter = 1'b1;
            end
         end
         TOT: begin
            if (!disc_i) begin
               state_d = ACQ;
               emit    = 1'b1;
            end else if (tot_q != '1) begin
               tot_d = tot_q + 1'b1;
            end
         end
         AZ: begin
            prev_d = 1'b1;
            if (cnt_q <= CNT_W'(1)) begin
               if (AZ_GUARD == 0) begin
                  state_d = ACQ;
               end else begin
                  state_d = GUARD;
                  cnt_d   = CNT_W'(AZ_GUARD);
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         GUARD: begin
            // A pulse still high when ACQ resumes must not look like a leading edge.
            prev_d = 1'b1;
            if (cnt_q <= CNT_W'(1))
               state_d = ACQ;
            else
               cnt_d = cnt_q - 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= AZ;
         cnt_q   <= CNT_W'(AZ_WIDTH);
         prev_q  <= 1'b1;
         tot_q   <= '0;
         ts_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         prev_q  <= prev_d;
         tot_q   <= tot_d;
         ts_q    <= ts_d;
      end
   end

   // AFE controls are registered copies of the current state, so they trail it by a cycle.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         phi_q    <= 1'b0;
         strobe_q <= 1'b0;
      end else begin
         phi_q    <= (state_q == AZ);
         strobe_q <= (state_q == ACQ) || (state_q == TOT);
      end
   end

   assign pop = vld_q && hit_o.ready;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         vld_q  <= 1'b0;
         ovf_q  <= 1'b0;
         otot_q <= '0;
         ots_q  <= '0;
      end else begin
         ovf_q <= 1'b0;
         if (emit && (!vld_q || pop)) begin
            vld_q  <= 1'b1;
            otot_q <= tot_q;
            ots_q  <= ts_q;
         end else if (emit) begin
            ovf_q <= 1'b1;
         end else if (pop) begin
            vld_q <= 1'b0;
         end
      end
   end

   assign phi_az_o    = phi_q;
   assign strobe_o    = strobe_q;
   assign ovf_o       = ovf_q;
   assign hit_o.valid = vld_q;
   assign hit_o.tot   = otot_q;
   assign hit_o.ts    = ots_q;

endmodule

// File: tb/tb_rd53_sync_fe_tot_ctrl.sv
// Directed bench for rd53_sync_fe_tot_ctrl: reset/auto-zero timing, ToT and
// timestamp capture, auto-zero deferral, backpressure, masking and mid-pulse reset.
module tb_rd53_sync_fe_tot_ctrl;
   import rd53_sync_fe_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0;
   logic       disc = 1'b0;
   logic       az_req = 1'b0;
   logic [7:0] bcid = 8'h00;
   logic       phi, strobe, ovf;

   int n_cmp = 0;
   int n_bad = 0;
   int ovf_cnt = 0;
   int vld_cnt = 0;
   logic [3:0] q_tot[$];
   logic [7:0] q_ts[$];

   rd53_sync_fe_tot_ctrl_if #(.TOT_W(4), .BCID_W(8)) hif ();

   rd53_sync_fe_tot_ctrl #(
      .TOT_W(4), .BCID_W(8), .AZ_PERIOD(1000), .AZ_WIDTH(4), .AZ_GUARD(2)
   ) dut (
      .clk_i    (clk),
      .rst_i    (rst),
      .en_i     (en),
      .disc_i   (disc),
      .bcid_i   (bcid),
      .az_req_i (az_req),
      .phi_az_o (phi),
      .strobe_o (strobe),
      .ovf_o    (ovf),
      .hit_o    (hif)
   );

   always #5 clk = ~clk;

   // Record accepted records and pulse counts half a cycle away from the active edge.
   always @(negedge clk) begin
      if (hif.valid === 1'b1 && hif.ready === 1'b1) begin
         q_tot.push_back(hif.tot);
         q_ts.push_back(hif.ts);
      end
      if (ovf === 1'b1) ovf_cnt++;
      if (hif.valid === 1'b1) vld_cnt++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
      bcid = bcid + 8'd1;
   endtask

   task automatic do_reset();
      rst = 1'b1; en = 1'b1; disc = 1'b0; az_req = 1'b0; hif.ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // Expects rst released just after a rising edge.
   task automatic check_seq(input string tag);
      logic ephi, estb;
      for (int k = 1; k <= 8; k++) begin
         tick();
         ephi = (k <= 4);
         estb = (k >= 7);
         n_cmp++;
         if (phi !== ephi) begin
            n_bad++;
            $display("FAIL %s_phi_c%0d: got %b want %b", tag, k, phi, ephi);
         end
         n_cmp++;
         if (strobe !== estb) begin
            n_bad++;
            $display("FAIL %s_strobe_c%0d: got %b want %b", tag, k, strobe, estb);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 1'b1; disc = 1'b0; az_req = 1'b0; hif.ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++;
      if ({phi, strobe, hif.valid, ovf} !== 4'b0000) begin
         n_bad++;
         $display("FAIL reset_outputs: got %b want 0000", {phi, strobe, hif.valid, ovf});
      end
      rst = 1'b0;
      check_seq("reset_seq");
   endtask

   task automatic test_single();
      int b, o;
      do_reset();
      repeat (8) tick();
      b = q_tot.size(); o = ovf_cnt;
      bcid = 8'h3A; disc = 1'b1;
      repeat (5) tick();
      disc = 1'b0;
      repeat (6) tick();
      n_cmp++;
      if (q_tot.size() - b != 1) begin
         n_bad++;
         $display("FAIL single_count: got %0d want 1", q_tot.size() - b);
      end else begin
         n_cmp++;
         if (q_tot[b] !== 4'd5) begin
            n_bad++;
            $display("FAIL single_tot: got %0d want 5", q_tot[b]);
         end
         n_cmp++;
         if (q_ts[b] !== 8'h3A) begin
            n_bad++;
            $display("FAIL single_ts: got %h want 3a", q_ts[b]);
         end
      end
      n_cmp++;
      if (ovf_cnt != o) begin
         n_bad++;
         $display("FAIL single_ovf: got %0d want 0", ovf_cnt - o);
      end
   endtask

   task automatic test_saturate();
      int b;
      do_reset();
      repeat (8) tick();
      b = q_tot.size();
      bcid = 8'hF0; disc = 1'b1;
      repeat (40) tick();
      disc = 1'b0;
      repeat (6) tick();
      n_cmp++;
      if (q_tot.size() - b != 1) begin
         n_bad++;
         $display("FAIL sat_count: got %0d want 1", q_tot.size() - b);
      end else begin
         n_cmp++;
         if (q_tot[b] !== 4'hF) begin
            n_bad++;
            $display("FAIL sat_tot: got %0d want 15", q_tot[b]);
         end
         n_cmp++;
         if (q_ts[b] !== 8'hF0) begin
            n_bad++;
            $display("FAIL sat_ts_wrap: got %h want f0", q_ts[b]);
         end
      end
   endtask

   task automatic test_az_mid_pulse();
      int b;
      do_reset();
      repeat (8) tick();
      b = q_tot.size();
      bcid = 8'h10; disc = 1'b1;
      repeat (3) tick();
      az_req = 1'b1;
      tick();
      az_req = 1'b0;
      repeat (3) tick();
      n_cmp++;
      if (phi !== 1'b0) begin
         n_bad++;
         $display("FAIL az_defer_in_tot: got %b want 0", phi);
      end
      disc = 1'b0;
      for (int c = 1; c <= 3; c++) begin
         tick();
         n_cmp++;
         if (phi !== (c == 3)) begin
            n_bad++;
            $display("FAIL az_rise_c%0d: got %b want %b", c, phi, (c == 3));
         end
      end
      repeat (3) tick();
      n_cmp++;
      if (phi !== 1'b1) begin
         n_bad++;
         $display("FAIL az_width_hi: got %b want 1", phi);
      end
      tick();
      n_cmp++;
      if (phi !== 1'b0) begin
         n_bad++;
         $display("FAIL az_width_lo: got %b want 0", phi);
      end
      n_cmp++;
      if (q_tot.size() - b != 1) begin
         n_bad++;
         $display("FAIL az_rec_count: got %0d want 1", q_tot.size() - b);
      end else begin
         n_cmp++;
         if (q_tot[b] !== 4'd7 || q_ts[b] !== 8'h10) begin
            n_bad++;
            $display("FAIL az_rec: got tot %0d ts %h want tot 7 ts 10", q_tot[b], q_ts[b]);
         end
      end
   endtask

   task automatic test_back_to_back();
      int b, o;
      do_reset();
      repeat (8) tick();
      b = q_tot.size(); o = ovf_cnt;
      hif.ready = 1'b0;
      bcid = 8'h20; disc = 1'b1;
      repeat (3) tick();
      disc = 1'b0;
      repeat (3) tick();
      bcid = 8'h55; disc = 1'b1;
      repeat (2) tick();
      disc = 1'b0;
      repeat (4) tick();
      n_cmp++;
      if (hif.valid !== 1'b1) begin
         n_bad++;
         $display("FAIL bp_held_valid: got %b want 1", hif.valid);
      end
      n_cmp++;
      if (ovf_cnt - o != 1) begin
         n_bad++;
         $display("FAIL bp_ovf_pulses: got %0d want 1", ovf_cnt - o);
      end
      hif.ready = 1'b1;
      repeat (3) tick();
      n_cmp++;
      if (q_tot.size() - b != 1) begin
         n_bad++;
         $display("FAIL bp_count: got %0d want 1", q_tot.size() - b);
      end else begin
         n_cmp++;
         if (q_tot[b] !== 4'd3 || q_ts[b] !== 8'h20) begin
            n_bad++;
            $display("FAIL bp_first_kept: got tot %0d ts %h want tot 3 ts 20", q_tot[b], q_ts[b]);
         end
      end
      n_cmp++;
      if (hif.valid !== 1'b0) begin
         n_bad++;
         $display("FAIL bp_drained: got %b want 0", hif.valid);
      end
   endtask

   task automatic test_mask();
      int b, v;
      do_reset();
      repeat (8) tick();
      v = vld_cnt;
      en = 1'b0;
      repeat (6) begin
         disc = 1'b1; tick();
         disc = 1'b0; tick();
      end
      repeat (3) tick();
      n_cmp++;
      if (vld_cnt != v) begin
         n_bad++;
         $display("FAIL mask_no_valid: got %0d valid cycles want 0", vld_cnt - v);
      end
      b = q_tot.size();
      en = 1'b1; bcid = 8'h77; disc = 1'b1;
      repeat (2) tick();
      en = 1'b0;
      repeat (2) tick();
      disc = 1'b0;
      repeat (4) tick();
      en = 1'b1;
      n_cmp++;
      if (q_tot.size() - b != 1) begin
         n_bad++;
         $display("FAIL en_fall_count: got %0d want 1", q_tot.size() - b);
      end else begin
         n_cmp++;
         if (q_tot[b] !== 4'd4 || q_ts[b] !== 8'h77) begin
            n_bad++;
            $display("FAIL en_fall_rec: got tot %0d ts %h want tot 4 ts 77", q_tot[b], q_ts[b]);
         end
      end
   endtask

   task automatic test_reset_in_tot();
      int b;
      do_reset();
      repeat (8) tick();
      hif.ready = 1'b0;
      disc = 1'b1;
      repeat (2) tick();
      disc = 1'b0;
      repeat (2) tick();
      disc = 1'b1;
      repeat (3) tick();
      n_cmp++;
      if (hif.valid !== 1'b1) begin
         n_bad++;
         $display("FAIL rst_pre_valid: got %b want 1", hif.valid);
      end
      b = q_tot.size();
      rst = 1'b1;
      #1;
      n_cmp++;
      if ({hif.valid, phi, strobe} !== 3'b000) begin
         n_bad++;
         $display("FAIL rst_async_clear: got %b want 000", {hif.valid, phi, strobe});
      end
      disc = 1'b0; hif.ready = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check_seq("rst_tot_seq");
      repeat (4) tick();
      n_cmp++;
      if (q_tot.size() != b) begin
         n_bad++;
         $display("FAIL rst_partial_dropped: got %0d records want 0", q_tot.size() - b);
      end
   endtask

   task automatic test_az_period();
      int   first, second;
      logic pp;
      first = 0; second = 0; pp = 1'b0;
      do_reset();
      for (int k = 1; k <= 2100; k++) begin
         tick();
         if (phi === 1'b1 && !pp) begin
            if (k > 1 && first == 0) first = k;
            else if (first != 0 && second == 0) second = k;
         end
         pp = phi;
      end
      n_cmp++;
      if (first != 1002) begin
         n_bad++;
         $display("FAIL period_first_rise: got cycle %0d want 1002", first);
      end
      n_cmp++;
      if (second - first != 1000) begin
         n_bad++;
         $display("FAIL period_interval: got %0d want 1000", second - first);
      end
   endtask

   initial begin
      hif.ready = 1'b1;
      test_reset();
      test_single();
      test_saturate();
      test_az_mid_pulse();
      test_back_to_back();
      test_mask();
      test_reset_in_tot();
      test_az_period();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
